// File: rtl/prog_launcher.sv
// Host-side initiator for the processor Start/Ack program handshake: runs NUM_PROGS
// programs back to back, timing each one and aborting on an Ack timeout.
module prog_launcher #(
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd4000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic        DutAck,
  output logic        DutReset,
  output logic        DutStart,
  output logic [3:0]  ProgIdx,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] CycleCount,
  output logic        CycleValid
);

  typedef enum logic [2:0] {IDLE, DRST, START, RUN, REPORT, DONE} state_t;

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
  localparam logic [3:0]  LAST_PROG  = 4'(NUM_PROGS - 1);

  state_t      state, stateNext;
  logic [15:0] phase, phaseNext;
  logic [15:0] cnt, cntNext, cntInc;
  logic        armed, armedNext;
  logic [3:0]  progIdxNext;
  logic        errorNext;
  logic [15:0] cycleCountNext;
  logic        cycleValidNext;

  always_comb begin
    stateNext      = state;
    phaseNext      = phase;
    cntNext        = cnt;
    cntInc         = cnt + 16'd1;
    armedNext      = armed;
    progIdxNext    = ProgIdx;
    errorNext      = Error;
    cycleCountNext = CycleCount;
    cycleValidNext = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Go) begin
          stateNext   = DRST;
          phaseNext   = '0;
          progIdxNext = '0;
          errorNext   = 1'b0;
        end
      end
      DRST: begin
        if (phase == RST_LAST) begin
          stateNext = START;
          phaseNext = '0;
        end else begin
          phaseNext = phase + 16'd1;
        end
      end
      START: begin
        if (phase == START_LAST) begin
          stateNext = RUN;
          phaseNext = '0;
          cntNext   = '0;
          armedNext = 1'b0;
        end else begin
          phaseNext = phase + 16'd1;
        end
      end
      RUN: begin
        cntNext = cntInc;
        if (!DutAck) armedNext = 1'b1;
        // Timeout is checked first so it wins over a same-cycle completion.
        if (cntInc == TIMEOUT) begin
          stateNext      = DONE;
          errorNext      = 1'b1;
          cycleCountNext = TIMEOUT;
          cycleValidNext = 1'b1;
        end else if (armed && DutAck) begin
          stateNext      = REPORT;
          cycleCountNext = cntInc;
          cycleValidNext = 1'b1;
        end
      end
      REPORT: begin
        if (ProgIdx == LAST_PROG) begin
          stateNext = DONE;
        end else begin
          stateNext   = DRST;
          phaseNext   = '0;
          progIdxNext = ProgIdx + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      phase      <= '0;
      cnt        <= '0;
      armed      <= 1'b0;
      DutReset   <= 1'b1;
      DutStart   <= 1'b0;
      ProgIdx    <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      CycleCount <= '0;
      CycleValid <= 1'b0;
    end else begin
      state      <= stateNext;
      phase      <= phaseNext;
      cnt        <= cntNext;
      armed      <= armedNext;
      DutReset   <= (stateNext == IDLE) || (stateNext == DRST) || (stateNext == DONE);
      DutStart   <= (stateNext == START);
      ProgIdx    <= progIdxNext;
      Busy       <= (stateNext != IDLE) && (stateNext != DONE);
      Done       <= (stateNext == DONE);
      Error      <= errorNext;
      CycleCount <= cycleCountNext;
      CycleValid <= cycleValidNext;
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed self-checking bench for prog_launcher: sequencing, Ack arming, timeout and restart.
module tb_prog_launcher;

  logic        Clk;
  logic        Reset;
  logic        Go;
  logic        DutAck;
  logic        DutReset;
  logic        DutStart;
  logic [3:0]  ProgIdx;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] CycleCount;
  logic        CycleValid;

  int checks   = 0;
  int failures = 0;

  prog_launcher #(
    .NUM_PROGS   (3),
    .RST_CYCLES  (2),
    .START_CYCLES(2),
    .TIMEOUT     (16'd50)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Go        (Go),
    .DutAck    (DutAck),
    .DutReset  (DutReset),
    .DutStart  (DutStart),
    .ProgIdx   (ProgIdx),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .CycleCount(CycleCount),
    .CycleValid(CycleValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulseGo();
    Go = 1'b1;
    tick();
    Go = 1'b0;
  endtask

  // Waits (bounded) until DutStart is seen falling; afterwards we are in RUN cycle 1.
  task automatic waitStartFall(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = DutStart;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (prev && !DutStart) begin
        ok = 1'b1;
        return;
      end
      prev = DutStart;
    end
  endtask

  // Runs one program whose Ack rises in RUN cycle 'delay'; returns at the REPORT sample.
  task automatic runAck(input int delay, output bit ok);
    waitStartFall(ok);
    if (!ok) return;
    for (int r = 1; r <= delay; r++) begin
      DutAck = (r == delay);
      tick();
    end
    DutAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset  = 1'b0;
    Go     = 1'b0;
    DutAck = 1'b0;
    #12;
    checks++; if (DutReset !== 1'b1) begin failures++; $display("FAIL reset_dutreset actual=%b required=1", DutReset); end
    checks++; if (DutStart !== 1'b0) begin failures++; $display("FAIL reset_dutstart actual=%b required=0", DutStart); end
    checks++; if ({Busy, Done, Error, CycleValid} !== 4'b0000) begin failures++; $display("FAIL reset_flags actual=%b required=0000", {Busy, Done, Error, CycleValid}); end
    checks++; if (ProgIdx !== 4'd0 || CycleCount !== 16'd0) begin failures++; $display("FAIL reset_values actual=%0d/%0d required=0/0", ProgIdx, CycleCount); end
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (Busy !== 1'b0 || DutReset !== 1'b1) begin failures++; $display("FAIL idle_after_release actual=%b%b required=01", Busy, DutReset); end
  endtask

  task automatic test_phases();
    int rstCnt = 0;
    int stCnt  = 0;
    int n      = 0;
    bit overlap = 1'b0;
    pulseGo();
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL go_busy actual=%b required=1", Busy); end
    while (DutReset === 1'b1 && n < 20) begin
      if (DutStart) overlap = 1'b1;
      rstCnt++;
      tick();
      n++;
    end
    while (DutStart === 1'b1 && n < 20) begin
      if (DutReset) overlap = 1'b1;
      stCnt++;
      tick();
      n++;
    end
    checks++; if (rstCnt != 2) begin failures++; $display("FAIL dutreset_len actual=%0d required=2", rstCnt); end
    checks++; if (stCnt != 2) begin failures++; $display("FAIL dutstart_len actual=%0d required=2", stCnt); end
    checks++; if (overlap) begin failures++; $display("FAIL reset_start_overlap actual=1 required=0"); end
  endtask

  task automatic test_reset_midrun();
    DutAck = 1'b0;
    tick();
    tick();
    checks++; if (Busy !== 1'b1 || DutStart !== 1'b0) begin failures++; $display("FAIL midrun_pre actual=%b%b required=10", Busy, DutStart); end
    #2;
    Reset = 1'b0;
    #1;
    checks++; if ({DutStart, DutReset, Busy} !== 3'b010) begin failures++; $display("FAIL async_reset actual=%b required=010", {DutStart, DutReset, Busy}); end
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({Busy, Done, CycleValid, DutReset} !== 4'b0001 || ProgIdx !== 4'd0) begin failures++; $display("FAIL after_reset_idle actual=%b/%0d required=0001/0", {Busy, Done, CycleValid, DutReset}, ProgIdx); end
  endtask

  task automatic test_normal();
    bit ok;
    pulseGo();
    for (int p = 0; p < 3; p++) begin
      runAck(10, ok);
      checks++; if (!ok) begin failures++; $display("FAIL normal_start_timeout prog=%0d actual=none required=DutStart fall", p); end
      checks++; if (CycleValid !== 1'b1 || CycleCount !== 16'd10 || ProgIdx !== 4'(p)) begin
        failures++; $display("FAIL normal_report prog=%0d actual=%b/%0d/%0d required=1/10/%0d", p, CycleValid, CycleCount, ProgIdx, p);
      end
    end
    tick();
    checks++; if ({Done, Error, Busy, CycleValid} !== 4'b1000) begin failures++; $display("FAIL normal_done actual=%b required=1000", {Done, Error, Busy, CycleValid}); end
  endtask

  task automatic test_stale_ack();
    bit ok;
    DutAck = 1'b1;
    pulseGo();
    waitStartFall(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stale_start_timeout actual=none required=DutStart fall"); end
    tick();
    checks++; if (CycleValid !== 1'b0) begin failures++; $display("FAIL stale_early_completion actual=%b required=0", CycleValid); end
    DutAck = 1'b0;
    tick();
    DutAck = 1'b1;
    tick();
    DutAck = 1'b0;
    checks++; if (CycleValid !== 1'b1 || CycleCount !== 16'd3) begin failures++; $display("FAIL stale_report actual=%b/%0d required=1/3", CycleValid, CycleCount); end
    for (int p = 1; p < 3; p++) begin
      runAck(4, ok);
      checks++; if (!ok || CycleCount !== 16'd4 || ProgIdx !== 4'(p) || CycleValid !== 1'b1) begin
        failures++; $display("FAIL stale_followup prog=%0d actual=%b/%0d/%0d required=1/4/%0d", p, CycleValid, CycleCount, ProgIdx, p);
      end
    end
    tick();
    checks++; if (Done !== 1'b1) begin failures++; $display("FAIL stale_done actual=%b required=1", Done); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early = 1'b0;
    bit startSeen = 1'b0;
    DutAck = 1'b0;
    pulseGo();
    waitStartFall(ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_start actual=none required=DutStart fall"); end
    for (int r = 1; r <= 49; r++) begin
      tick();
      if (CycleValid || Done || Error) early = 1'b1;
    end
    checks++; if (early) begin failures++; $display("FAIL timeout_early actual=1 required=0"); end
    tick();
    checks++; if ({Error, CycleValid, Done, Busy} !== 4'b1110 || CycleCount !== 16'd50) begin
      failures++; $display("FAIL timeout_abort actual=%b/%0d required=1110/50", {Error, CycleValid, Done, Busy}, CycleCount);
    end
    checks++; if (ProgIdx !== 4'd0) begin failures++; $display("FAIL timeout_progidx actual=%0d required=0", ProgIdx); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DutStart || Busy || CycleValid) startSeen = 1'b1;
    end
    checks++; if (startSeen) begin failures++; $display("FAIL timeout_no_more_progs actual=1 required=0"); end
    checks++; if ({Done, Error, DutReset} !== 3'b111 || CycleCount !== 16'd50) begin
      failures++; $display("FAIL timeout_hold actual=%b/%0d required=111/50", {Done, Error, DutReset}, CycleCount);
    end
  endtask

  task automatic test_go_ignored();
    bit ok;
    pulseGo();
    checks++; if ({Error, Done, Busy} !== 3'b001 || ProgIdx !== 4'd0) begin
      failures++; $display("FAIL restart_clear actual=%b/%0d required=001/0", {Error, Done, Busy}, ProgIdx);
    end
    waitStartFall(ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_start actual=none required=DutStart fall"); end
    for (int r = 1; r <= 6; r++) begin
      Go     = (r == 3);
      DutAck = (r == 6);
      tick();
    end
    Go     = 1'b0;
    DutAck = 1'b0;
    checks++; if (CycleValid !== 1'b1 || CycleCount !== 16'd6 || ProgIdx !== 4'd0) begin
      failures++; $display("FAIL go_in_run_ignored actual=%b/%0d/%0d required=1/6/0", CycleValid, CycleCount, ProgIdx);
    end
    for (int p = 1; p < 3; p++) begin
      runAck(10, ok);
      checks++; if (!ok || CycleCount !== 16'd10 || ProgIdx !== 4'(p)) begin
        failures++; $display("FAIL restart_followup prog=%0d actual=%0d/%0d required=10/%0d", p, CycleCount, ProgIdx, p);
      end
    end
    tick();
    checks++; if ({Done, Error} !== 2'b10) begin failures++; $display("FAIL restart_done actual=%b required=10", {Done, Error}); end
  endtask

  task automatic test_back_to_back();
    Go = 1'b1;
    tick();
    checks++; if ({Busy, Done, DutReset} !== 3'b101) begin failures++; $display("FAIL go_held_restart actual=%b required=101", {Busy, Done, DutReset}); end
    tick();
    Go = 1'b0;
    checks++; if (Busy !== 1'b1 || ProgIdx !== 4'd0) begin failures++; $display("FAIL go_held_progress actual=%b/%0d required=1/0", Busy, ProgIdx); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_phases();
    test_reset_midrun();
    test_normal();
    test_stale_ack();
    test_timeout();
    test_go_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
